conv_via_tiling_acc_stage: RTL and testbench
============================================

CONV_VIA_TILING_ACC_STAGE -- requirements
Module: conv_via_tiling_acc_stage

Interface
REQ-001 Parameter DIN_WIDTH, 32, signed product width from the upstream multiplier.
REQ-002 Parameter ACC_WIDTH, 40, internal signed accumulator width; ACC_WIDTH SHALL be at least DIN_WIDTH.
REQ-003 Parameter DOUT_WIDTH, 32, signed result width; DOUT_WIDTH SHALL be at most ACC_WIDTH.
REQ-004 Parameter CNT_WIDTH, 16, width of the group length.
REQ-005 ap_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 ap_rst  in  1  reset, asynchronous and active-high.
REQ-007 len  in  CNT_WIDTH  unsigned products per output; sampled on the first accepted beat of a group.
REQ-008 bias  in  DOUT_WIDTH  signed initial value; sampled on the first accepted beat of a group.
REQ-009 in_valid  in  1  product beat valid.
REQ-010 in_ready  out  1  stage accepts a beat.
REQ-011 in_data  in  DIN_WIDTH  signed product.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_data  out  DOUT_WIDTH  signed accumulated result.
REQ-015 out_ovf  out  1  result was clamped (see Configuration).

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high on a clock edge; a result is taken when out_valid and out_ready are both high.
REQ-017 FSM states: IDLE, ACC, HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0. On an accepted beat: acc = sign-extended bias + sign-extended in_data, cnt = 1, len_q = len. If len is 0 or 1, go to HOLD; otherwise go to ACC.
REQ-019 len = 0 SHALL be treated as len = 1.
REQ-020 ACC: in_ready=1, out_valid=0. On each accepted beat: acc += sign-extended in_data and cnt += 1. When the beat makes cnt equal len_q, go to HOLD. With no beat, hold state.
REQ-021 HOLD: in_ready=0, out_valid=1, and out_data/out_ovf stay stable until taken. When taken, go to IDLE.
REQ-022 Latency: out_valid rises on the first edge after the last beat is accepted. Minimum gap between groups is one cycle, because a new group starts only from IDLE.
REQ-023 Accumulator arithmetic is two's-complement modulo 2^ACC_WIDTH; internal wrap is not flagged.
REQ-024 out_data and out_ovf SHALL be driven from registers; no combinational path from in_* to out_*.
REQ-025 out_ready held high outside HOLD has no effect.

Reset
REQ-026 ap_rst high SHALL force, immediately and without a clock: state=IDLE, acc=0, cnt=0, len_q=0, out_valid=0, out_data=0, out_ovf=0, in_ready=1 (combinational from IDLE).
REQ-027 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result. No output is produced for that group.
REQ-028 After reset deasserts, the first accepted beat starts a new group.

Configuration
REQ-029 Macro CONV_VIA_TILING_ACC_SAT_EN. When defined, acc is converted to out_data by clamping to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], and out_ovf=1 when a clamp occurred.
REQ-030 When the macro is not defined, out_data = acc[DOUT_WIDTH-1:0] (truncation) and out_ovf is constant 0.
REQ-031 The conversion SHALL be registered when entering HOLD in both builds.

Verification
REQ-032 len=3, bias=10, beats 5,-2,7, out_ready=1 -> out_valid one cycle after the third beat, out_data=20, out_ovf=0, then back to IDLE.
REQ-033 len=0, bias=-4, single beat 4 -> out_data=0 after one cycle; a second beat offered during HOLD is not accepted (in_ready=0).
REQ-034 len=2, bias=0, beats 0x7FFFFFFF and 0x7FFFFFFF -> with SAT_EN: out_data=0x7FFFFFFF, out_ovf=1; without SAT_EN: out_data=0xFFFFFFFE, out_ovf=0.
REQ-035 len=2, out_ready low for 5 cycles in HOLD -> out_valid and out_data stable for all 5 cycles; the result is taken on the first cycle out_ready is high.
REQ-036 len=4, ap_rst pulsed after 2 beats -> outputs zero immediately with no result; the next group len=1, bias=3, beat 1 -> out_data=4.
REQ-037 in_valid toggled 1,0,1,0,1 with len=3 -> gaps ignored; out_data equals bias plus the three accepted products.

Source files
------------

// File: rtl/conv_via_tiling_acc_stage.sv
// Accumulates a group of signed products onto a bias and holds the result until taken.
// Define CONV_VIA_TILING_ACC_SAT_EN to clamp the result to DOUT_WIDTH (default: truncate).
module conv_via_tiling_acc_stage #(
  parameter int unsigned DIN_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DOUT_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN_WIDTH-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] out_data,
  output logic                  out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [DOUT_WIDTH-1:0] r_out_data;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [ACC_WIDTH-1:0]  w_din_ext;
  logic [ACC_WIDTH-1:0]  w_bias_ext;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_last;
  logic [DOUT_WIDTH-1:0] w_conv;

  assign in_ready   = (r_state == StIdle) || (r_state == StAcc);
  assign out_valid  = (r_state == StHold);
  assign out_data   = r_out_data;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  assign w_din_ext  = ACC_WIDTH'($signed(in_data));
  assign w_bias_ext = ACC_WIDTH'($signed(bias));

  // The first beat of a group starts from the bias instead of the running sum.
  assign w_acc_nxt = ((r_state == StIdle) ? w_bias_ext : r_acc) + w_din_ext;
  assign w_cnt_nxt = (r_state == StIdle) ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
  assign w_last    = (r_state == StIdle) ? (len <= CNT_WIDTH'(1)) : (w_cnt_nxt == r_len);

`ifdef CONV_VIA_TILING_ACC_SAT_EN
  logic [ACC_WIDTH-DOUT_WIDTH:0] w_upper;
  logic                          w_fits;
  logic                          r_out_ovf;

  // Result fits when all bits from the output sign bit upward agree.
  assign w_upper = w_acc_nxt[ACC_WIDTH-1:DOUT_WIDTH-1];
  assign w_fits  = (&w_upper) | ~(|w_upper);
  assign w_conv  = w_fits ? w_acc_nxt[DOUT_WIDTH-1:0] :
                   w_acc_nxt[ACC_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} :
                                            {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  assign out_ovf = r_out_ovf;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_ovf <= 1'b0;
    end else if (w_in_fire && w_last) begin
      r_out_ovf <= ~w_fits;
    end
  end
`else
  assign w_conv  = w_acc_nxt[DOUT_WIDTH-1:0];
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        StIdle, StAcc: begin
          if (w_in_fire) begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            if (r_state == StIdle) begin
              r_len <= len;
            end
            if (w_last) begin
              r_state    <= StHold;
              r_out_data <= w_conv;
            end else begin
              r_state <= StAcc;
            end
          end
        end
        StHold: begin
          if (w_out_fire) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_via_tiling_acc_stage.sv
// Directed self-checking bench for conv_via_tiling_acc_stage.
// Expected values are hand-computed; saturation expectations follow CONV_VIA_TILING_ACC_SAT_EN.
module tb_conv_via_tiling_acc_stage;

  logic        ap_clk;
  logic        ap_rst;
  logic [15:0] len;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;

  int n_checks;
  int n_fail;

  conv_via_tiling_acc_stage #(
    .DIN_WIDTH (32),
    .ACC_WIDTH (40),
    .DOUT_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .len      (len),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    ap_rst    = 1'b1;
    len       = '0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    step();
    ap_rst = 1'b0;
    step();

    // Group: len=3, bias=10, beats 5,-2,7 -> 20
    len = 16'd3; bias = 32'd10; out_ready = 1'b1;
    beat(32'd5);
    chk("g1_b1_valid", 64'(out_valid), 64'd0);
    chk("g1_b1_ready", 64'(in_ready),  64'd1);
    beat(-32'sd2);
    chk("g1_b2_valid", 64'(out_valid), 64'd0);
    beat(32'd7);
    chk("g1_valid", 64'(out_valid), 64'd1);
    chk("g1_data",  64'(out_data),  64'd20);
    chk("g1_ovf",   64'(out_ovf),   64'd0);
    chk("g1_hold_ready", 64'(in_ready), 64'd0);
    step();
    chk("g1_taken_valid", 64'(out_valid), 64'd0);
    chk("g1_idle_ready",  64'(in_ready),  64'd1);

    // len=0 acts as 1: bias=-4, beat 4 -> 0; beat offered in HOLD must be refused
    len = 16'd0; bias = -32'sd4; out_ready = 1'b0;
    beat(32'd4);
    chk("g2_valid", 64'(out_valid), 64'd1);
    chk("g2_data",  64'(out_data),  64'd0);
    in_valid = 1'b1; in_data = 32'd100;
    chk("g2_hold_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    chk("g2_hold_valid", 64'(out_valid), 64'd1);
    chk("g2_hold_data",  64'(out_data),  64'd0);
    out_ready = 1'b1;
    step();
    chk("g2_taken_valid", 64'(out_valid), 64'd0);

    // Overflow: 0x7FFFFFFF + 0x7FFFFFFF
    len = 16'd2; bias = 32'd0;
    beat(32'h7FFF_FFFF);
    beat(32'h7FFF_FFFF);
    chk("g3_valid", 64'(out_valid), 64'd1);
`ifdef CONV_VIA_TILING_ACC_SAT_EN
    chk("g3_data", 64'(out_data), 64'h7FFF_FFFF);
    chk("g3_ovf",  64'(out_ovf),  64'd1);
`else
    chk("g3_data", 64'(out_data), 64'hFFFF_FFFE);
    chk("g3_ovf",  64'(out_ovf),  64'd0);
`endif
    step();
    chk("g3_taken_valid", 64'(out_valid), 64'd0);

    // Backpressure: len=2, bias=1, beats 2,3 -> 6 held for 5 cycles
    len = 16'd2; bias = 32'd1; out_ready = 1'b0;
    beat(32'd2);
    beat(32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("g4_bp_valid", 64'(out_valid), 64'd1);
      chk("g4_bp_data",  64'(out_data),  64'd6);
      step();
    end
    out_ready = 1'b1;
    chk("g4_pre_take_valid", 64'(out_valid), 64'd1);
    step();
    chk("g4_taken_valid", 64'(out_valid), 64'd0);
    chk("g4_kept_data",   64'(out_data),  64'd6);

    // Reset mid-group discards it; next group len=1, bias=3, beat 1 -> 4
    len = 16'd4; bias = 32'd100;
    beat(32'd1);
    beat(32'd2);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data",  64'(out_data),  64'd0);
    chk("rst_mid_ready", 64'(in_ready),  64'd1);
    #1;
    ap_rst = 1'b0;
    step();
    step();
    chk("post_rst_no_result", 64'(out_valid), 64'd0);
    len = 16'd1; bias = 32'd3;
    beat(32'd1);
    chk("g5_valid", 64'(out_valid), 64'd1);
    chk("g5_data",  64'(out_data),  64'd4);
    step();
    chk("g5_taken_valid", 64'(out_valid), 64'd0);

    // Gapped input: len=3, bias=-1, accepted 10,20,30 -> 59; gap data ignored
    len = 16'd3; bias = -32'sd1;
    beat(32'd10);
    in_data = 32'd99;
    step();
    chk("g6_gap1_valid", 64'(out_valid), 64'd0);
    chk("g6_gap1_ready", 64'(in_ready),  64'd1);
    beat(32'd20);
    in_data = 32'd99;
    step();
    chk("g6_gap2_valid", 64'(out_valid), 64'd0);
    beat(32'd30);
    chk("g6_valid", 64'(out_valid), 64'd1);
    chk("g6_data",  64'(out_data),  64'd59);
    step();
    chk("g6_taken_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
